// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 32-bit immediate into the I/U/J/S/B fields of an
// instruction template, and expands the load-immediate pseudo-op into ADDI or
// LUI(+ADDI). Valid/ready on both sides, one-cycle registered output.
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic        in_li,
  input  logic [31:0] in_base,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic        out_last
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FMT_W = 3;
  localparam int unsigned RD_W  = 5;
  localparam int unsigned OPC_W = 7;

  localparam logic [FMT_W-1:0] FMT_I = 3'd0;
  localparam logic [FMT_W-1:0] FMT_U = 3'd1;
  localparam logic [FMT_W-1:0] FMT_J = 3'd2;
  localparam logic [FMT_W-1:0] FMT_S = 3'd3;
  localparam logic [FMT_W-1:0] FMT_B = 3'd4;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_EMIT2 = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_inst_q,  out_inst_d;
  logic            out_err_q,   out_err_d;
  logic            out_last_q,  out_last_d;
  logic [XLEN-1:0] word2_q,     word2_d;

  // Encoder results for the request currently presented on the input side
  logic [XLEN-1:0] enc_inst;
  logic            enc_err;
  logic            enc_last;
  logic            enc_two;
  logic [XLEN-1:0] enc_word2;

  // Handshake / load controls produced by the FSM output logic
  logic load_new;
  logic load_w2;
  logic drain;

  // Range helpers: an immediate fits N signed bits when its upper bits are a
  // pure sign extension of bit N-1.
  logic [RD_W-1:0] rd;
  logic            fits12;
  logic            fits13;
  logic            fits21;
  logic [19:0]     li_hi;

  assign rd     = in_base[11:7];
  assign fits12 = (&in_imm[31:11]) || (~|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) || (~|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) || (~|in_imm[31:20]);

  // Adding 0x800 before taking the upper 20 bits only carries into bit 12
  // when imm[11] is set, so the LUI part is imm[31:12] + imm[11] (mod 2^20).
  assign li_hi  = 20'(in_imm[31:12] + 20'(in_imm[11]));

  // Field packing, range check and LI expansion for the incoming request
  always_comb begin
    enc_inst  = in_base;
    enc_err   = 1'b0;
    enc_last  = 1'b1;
    enc_two   = 1'b0;
    enc_word2 = '0;
    if (in_li) begin
      if (fits12) begin
        enc_inst = {in_imm[11:0], 5'd0, 3'b000, rd, OPC_OP_IMM};
      end else begin
        enc_inst = {li_hi, rd, OPC_LUI};
        if (in_imm[11:0] != 12'd0) begin
          enc_last  = 1'b0;
          enc_two   = 1'b1;
          enc_word2 = {in_imm[11:0], rd, 3'b000, rd, OPC_OP_IMM};
        end
      end
    end else begin
      case (in_fmt)
        FMT_I: begin
          enc_inst = {in_imm[11:0], in_base[19:0]};
          enc_err  = !fits12;
        end
        FMT_U: begin
          enc_inst = {in_imm[31:12], in_base[11:0]};
          enc_err  = (in_imm[11:0] != 12'd0);
        end
        FMT_J: begin
          enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                      in_base[11:0]};
          enc_err  = !fits21 || in_imm[0];
        end
        FMT_S: begin
          enc_inst = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
          enc_err  = !fits12;
        end
        FMT_B: begin
          enc_inst = {in_imm[12], in_imm[10:5], in_base[24:12], in_imm[4:1],
                      in_imm[11], in_base[6:0]};
          enc_err  = !fits13 || in_imm[0];
        end
        default: begin
          enc_inst = in_base;
          enc_err  = 1'b1;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stay in EMIT2 until word 1 is handed off
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_new && enc_two) begin
          state_d = S_EMIT2;
        end
      end
      S_EMIT2: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: input-side ready and output-register load selects
  always_comb begin
    in_ready = 1'b0;
    load_new = 1'b0;
    load_w2  = 1'b0;
    drain    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = !out_valid_q || out_ready;
        load_new = in_valid && (!out_valid_q || out_ready);
        drain    = out_valid_q && out_ready && !load_new;
      end
      S_EMIT2: begin
        load_w2 = out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Output register next values: new word, queued second word, or drain
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    out_last_d  = out_last_q;
    word2_d     = word2_q;
    if (load_new) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_inst;
      out_err_d   = enc_err;
      out_last_d  = enc_last;
      word2_d     = enc_word2;
    end else if (load_w2) begin
      out_valid_d = 1'b1;
      out_inst_d  = word2_q;
      out_err_d   = 1'b0;
      out_last_d  = 1'b1;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Output and pending-word registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      word2_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
      word2_q     <= word2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder: directed test-plan sequences plus randomized
// traffic, all checked against an arithmetic reference model and scoreboard.
module tb_imm_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic        in_li;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic        out_last;

  logic rand_ready;
  logic rnd_bit;
  logic fixed_ready;
  int   total;
  int   bad;
  int   cyc;
  int   accepts;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
    logic        last;
  } word_t;

  word_t sbq[$];

  imm_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_li     (in_li),
    .in_base   (in_base),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign out_ready = rand_ready ? rnd_bit : fixed_ready;

  always @(negedge clk) rnd_bit = ($urandom_range(0, 3) != 0);
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: words the encoder must emit for one request.
  task automatic model(input logic li, input logic [2:0] fmt, input logic [31:0] base,
                       input logic [31:0] imm, output int n, output word_t w0, output word_t w1);
    int s;
    logic [31:0] rd, hi, lo;
    s  = $signed(imm);
    rd = (base >> 7) & 32'h1F;
    n  = 1;
    w0 = '0;
    w1 = '0;
    w0.last = 1'b1;
    if (li) begin
      if (s >= -2048 && s <= 2047) begin
        w0.inst = ((imm & 32'hFFF) << 20) | (rd << 7) | 32'h13;
      end else begin
        hi = (imm + 32'h800) >> 12;
        lo = imm & 32'hFFF;
        w0.inst = (hi << 12) | (rd << 7) | 32'h37;
        if (lo != 0) begin
          n = 2;
          w0.last = 1'b0;
          w1.inst = (lo << 20) | (rd << 15) | (rd << 7) | 32'h13;
          w1.last = 1'b1;
        end
      end
    end else begin
      case (fmt)
        3'd0: begin
          w0.inst = (base & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
          w0.err  = !(s >= -2048 && s <= 2047);
        end
        3'd1: begin
          w0.inst = (base & 32'hFFF) | (imm & 32'hFFFF_F000);
          w0.err  = ((imm & 32'hFFF) != 0);
        end
        3'd2: begin
          w0.inst = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                  | (base & 32'hFFF);
          w0.err  = !(s >= -1048576 && s <= 1048574 && imm[0] == 1'b0);
        end
        3'd3: begin
          w0.inst = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7)
                  | (base & 32'h01FF_F07F);
          w0.err  = !(s >= -2048 && s <= 2047);
        end
        3'd4: begin
          w0.inst = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7)
                  | (base & 32'h01FF_F07F);
          w0.err  = !(s >= -4096 && s <= 4094 && imm[0] == 1'b0);
        end
        default: begin
          w0.inst = base;
          w0.err  = 1'b1;
        end
      endcase
    end
  endtask

  // Scoreboard compare: sampled 2 time units after the driving negedge
  always @(negedge clk) begin
    int    n;
    word_t w0, w1;
    logic  exp_ready;
    #2;
    if (!rst_n) begin
      sbq.delete();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_inst", out_inst, 32'd0);
    end else begin
      exp_ready = (sbq.size() == 0) || (sbq.size() == 1 && out_ready);
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
      if (out_valid && sbq.size() != 0) begin
        check("out_inst", out_inst, sbq[0].inst);
        check("out_err", 32'(out_err), 32'(sbq[0].err));
        check("out_last", 32'(out_last), 32'(sbq[0].last));
        if (out_ready) void'(sbq.pop_front());
      end
      if (in_valid && in_ready) begin
        model(in_li, in_fmt, in_base, in_imm, n, w0, w1);
        sbq.push_back(w0);
        if (n == 2) sbq.push_back(w1);
        accepts++;
      end
    end
  end

  // Present one request, waiting a bounded number of cycles for acceptance
  task automatic send(input logic li, input logic [2:0] fmt, input logic [31:0] base,
                      input logic [31:0] imm);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_li    = li;
    in_fmt   = fmt;
    in_base  = base;
    in_imm   = imm;
    for (int k = 0; k < 64 && !done; k++) begin
      #1;
      if (in_ready) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no in_ready expected in_ready=1 (t=%0t)", $time);
    end
  endtask

  // Model pinning against hand-computed encodings
  task automatic pin_model();
    int n;
    word_t w0, w1;
    model(1'b0, 3'd0, 32'h93, 32'hFFFF_FFFF, n, w0, w1);
    check("pin_I_inst", w0.inst, 32'hFFF0_0093);
    check("pin_I_err", 32'(w0.err), 32'd0);
    model(1'b0, 3'd4, 32'h63, 32'hFFFF_FFFC, n, w0, w1);
    check("pin_B_inst", w0.inst, 32'hFE00_0EE3);
    check("pin_B_err", 32'(w0.err), 32'd0);
    model(1'b0, 3'd4, 32'h63, 32'd3, n, w0, w1);
    check("pin_B_odd_err", 32'(w0.err), 32'd1);
    model(1'b1, 3'd0, 32'(5 << 7), 32'h1234_5678, n, w0, w1);
    check("pin_LI2_n", 32'(n), 32'd2);
    check("pin_LI2_w1", w0.inst, 32'h1234_52B7);
    check("pin_LI2_w1_last", 32'(w0.last), 32'd0);
    check("pin_LI2_w2", w1.inst, 32'h6782_8293);
    model(1'b1, 3'd0, 32'(1 << 7), 32'h0000_1000, n, w0, w1);
    check("pin_LI_lui", w0.inst, 32'h0000_10B7);
    check("pin_LI_lui_n", 32'(n), 32'd1);
    model(1'b1, 3'd0, 32'(1 << 7), 32'hFFFF_FFFB, n, w0, w1);
    check("pin_LI_addi", w0.inst, 32'hFFB0_0093);
    model(1'b0, 3'd2, 32'h6F, 32'd2048, n, w0, w1);
    check("pin_J_inst", w0.inst, 32'h0010_006F);
    model(1'b1, 3'd0, 32'h0, 32'h7FFF_F800, n, w0, w1);
    check("pin_LI_wrap_w1", w0.inst, 32'h8000_0037);
    check("pin_LI_wrap_w2", w1.inst, 32'h8000_0013);
    model(1'b0, 3'd5, 32'hDEAD_BEEF, 32'd7, n, w0, w1);
    check("pin_bad_fmt_inst", w0.inst, 32'hDEAD_BEEF);
    check("pin_bad_fmt_err", 32'(w0.err), 32'd1);
  endtask

  logic [31:0] edge_imm [17] = '{
    32'hFFFF_F800, 32'd2047, 32'd2048, 32'hFFFF_F7FF, 32'hFFFF_F000, 32'd4094,
    32'd4095, 32'hFFFF_EFFF, 32'd4096, 32'hFFF0_0000, 32'd1048574, 32'd1048576,
    32'h7FFF_F800, 32'h8000_0000, 32'd0, 32'h0000_1000, 32'hFFFF_F000
  };

  initial begin
    int c0, a0;
    logic [31:0] imm;
    total = 0; bad = 0; cyc = 0; accepts = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_li = 1'b0; in_fmt = '0;
    in_base = '0; in_imm = '0; rand_ready = 1'b0; fixed_ready = 1'b0;

    pin_model();

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fixed_ready = 1'b1;
    @(negedge clk);

    // Directed: test-plan requests
    send(1'b0, 3'd0, 32'h93, 32'hFFFF_FFFF);
    send(1'b0, 3'd4, 32'h63, 32'hFFFF_FFFC);
    send(1'b0, 3'd4, 32'h63, 32'd3);
    send(1'b1, 3'd0, 32'(1 << 7), 32'h0000_1000);
    send(1'b1, 3'd0, 32'(1 << 7), 32'hFFFF_FFFB);
    send(1'b1, 3'd0, 32'h0, 32'h7FFF_F800);
    repeat (3) @(negedge clk);

    // LI two-word expansion with a stalled consumer
    fixed_ready = 1'b0;
    send(1'b1, 3'd0, 32'(5 << 7), 32'h1234_5678);
    repeat (3) @(negedge clk);
    fixed_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Back-to-back J requests: one accept per cycle
    c0 = cyc;
    a0 = accepts;
    for (int i = 0; i < 8; i++) send(1'b0, 3'd2, 32'h6F, 32'(2048 + 2 * i));
    check("b2b_cycles", 32'(cyc - c0), 32'd8);
    check("b2b_accepts", 32'(accepts - a0), 32'd8);
    repeat (2) @(negedge clk);

    // Reset while the second LI word is pending
    fixed_ready = 1'b0;
    send(1'b1, 3'd0, 32'(7 << 7), 32'h1234_5678);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fixed_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Randomized traffic with random consumer backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: imm = $urandom();
        1: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
        2: imm = edge_imm[$urandom_range(0, 16)];
        default: imm = $urandom() & 32'hFFFF_F000;
      endcase
      send(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), $urandom(), imm);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    rand_ready = 1'b0;
    fixed_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
